// File: rtl/radix4_mult_ctrl.sv
// Radix-4 Booth multiplier controller: sequences load, Booth-digit accumulate and 2-place shift.
// Optional macro RADIX4_MULT_CTRL_ABORT_EN adds an abort input that cancels an operation.
module radix4_mult_ctrl #(
    parameter int unsigned size = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [1:0] q_bits,
    output logic       load_enable,
    output logic       shift_enable,
    output logic       clear_n,
    output logic       acc_en,
    output logic [2:0] pp_sel,
    output logic       out_valid,
    input  logic       out_ready
`ifdef RADIX4_MULT_CTRL_ABORT_EN
    ,
    input  logic       abort
`endif
);

    localparam int unsigned Digits = size / 2;
    localparam int unsigned CntW   = $clog2(Digits + 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(Digits);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StCalc,
        StShift,
        StDone
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            qm1_q, qm1_d;
    logic [2:0]      booth_sel;
    logic            abort_act;

`ifdef RADIX4_MULT_CTRL_ABORT_EN
    assign abort_act = abort && (state_q != StIdle);
`else
    assign abort_act = 1'b0;
`endif

    // Booth digit of {q1, q0, q-1}; encoding is {negate, x2, x1}
    always_comb begin
        booth_sel = 3'b000;
        case ({q_bits, qm1_q})
            3'b001, 3'b010: booth_sel = 3'b001;
            3'b011:         booth_sel = 3'b010;
            3'b100:         booth_sel = 3'b110;
            3'b101, 3'b110: booth_sel = 3'b101;
            default:        booth_sel = 3'b000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            qm1_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            qm1_q   <= qm1_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        qm1_d        = qm1_q;
        in_ready     = 1'b0;
        load_enable  = 1'b0;
        shift_enable = 1'b0;
        clear_n      = 1'b1;
        acc_en       = 1'b0;
        pp_sel       = 3'b000;
        out_valid    = 1'b0;

        case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                if (in_valid) state_d = StLoad;
            end
            StLoad: begin
                load_enable = 1'b1;
                cnt_d       = '0;
                qm1_d       = 1'b0;
                state_d     = StCalc;
            end
            StCalc: begin
                acc_en  = 1'b1;
                pp_sel  = booth_sel;
                state_d = StShift;
            end
            StShift: begin
                shift_enable = 1'b1;
                qm1_d        = q_bits[1];
                cnt_d        = cnt_q + CntW'(1);
                state_d      = (cnt_d == LastCnt) ? StDone : StCalc;
            end
            StDone: begin
                out_valid = 1'b1;
                if (out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (abort_act) begin
            state_d      = StIdle;
            cnt_d        = '0;
            qm1_d        = 1'b0;
            in_ready     = 1'b0;
            load_enable  = 1'b0;
            shift_enable = 1'b0;
            acc_en       = 1'b0;
            pp_sel       = 3'b000;
            out_valid    = 1'b0;
            clear_n      = 1'b0;
        end

        // Reset clears the external shift registers on the same edge it resets the FSM
        if (reset) begin
            in_ready     = 1'b0;
            load_enable  = 1'b0;
            shift_enable = 1'b0;
            acc_en       = 1'b0;
            pp_sel       = 3'b000;
            out_valid    = 1'b0;
            clear_n      = 1'b0;
        end
    end

endmodule

// File: tb/tb_radix4_mult_ctrl.sv
// Self-checking bench for radix4_mult_ctrl: models the shift register and Booth accumulator,
// scoreboards expected pp_sel digits and products per accepted operation.
module tb_radix4_mult_ctrl;

    localparam int unsigned Size   = 8;
    localparam int unsigned Digits = Size / 2;
    localparam int unsigned Lat    = 2 + Size;

    logic            clk = 1'b0;
    logic            reset, in_valid, in_ready, load_enable, shift_enable, clear_n, acc_en;
    logic            out_valid, out_ready, abort;
    logic [1:0]      q_bits;
    logic [2:0]      pp_sel;
    logic [Size-1:0] mult_v, mcand_v, mreg;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    radix4_mult_ctrl #(.size(Size)) u_dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .q_bits       (q_bits),
        .load_enable  (load_enable),
        .shift_enable (shift_enable),
        .clear_n      (clear_n),
        .acc_en       (acc_en),
        .pp_sel       (pp_sel),
        .out_valid    (out_valid),
        .out_ready    (out_ready)
`ifdef RADIX4_MULT_CTRL_ABORT_EN
        ,
        .abort        (abort)
`endif
    );

    task automatic check_eq(input string tag, input logic signed [31:0] obs,
                            input logic signed [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int pp_val(input logic [2:0] s);
        case (s)
            3'b000:  return 0;
            3'b001:  return 1;
            3'b010:  return 2;
            3'b101:  return -1;
            3'b110:  return -2;
            default: return 99;
        endcase
    endfunction

    function automatic int booth_exp(input logic [2:0] t);
        case (t)
            3'b001, 3'b010: return 1;
            3'b011:         return 2;
            3'b100:         return 6;
            3'b101, 3'b110: return 5;
            default:        return 0;
        endcase
    endfunction

    // Datapath model: multiplier shift register and accumulator driven by the DUT strobes
    int mcand_r, acc, idx;
    assign q_bits = mreg[1:0];

    always @(posedge clk) begin
        if (!clear_n) begin
            mreg <= '0;
        end else if (load_enable) begin
            mreg    <= mult_v;
            mcand_r <= $signed(mcand_v);
            acc     <= 0;
            idx     <= 0;
        end else if (shift_enable) begin
            mreg <= {2'b00, mreg[Size-1:2]};
            idx  <= idx + 1;
        end else if (acc_en) begin
            acc <= acc + ((pp_val(pp_sel) * mcand_r) <<< (2 * idx));
        end
    end

    // Scoreboard monitor, sampling on the falling edge
    int   pp_q[$];
    int   prod_q[$];
    int   cyc = 0, acc_cyc = 0, shifts = 0;
    logic ov_prev = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            check_eq("strobe_excl", 32'($countones({load_enable, shift_enable, acc_en}) > 1), 0);
            if (!acc_en) check_eq("pp_idle_zero", pp_sel, 0);
            if (reset || abort) begin
                pp_q.delete();
                prod_q.delete();
            end else begin
                if (in_ready && in_valid) begin
                    logic [Size:0] ext;
                    int a, b;
                    ext = {mult_v, 1'b0};
                    for (int i = 0; i < Digits; i++) pp_q.push_back(booth_exp(ext[2*i +: 3]));
                    a = $signed(mult_v);
                    b = $signed(mcand_v);
                    prod_q.push_back(a * b);
                    acc_cyc = cyc;
                    shifts  = 0;
                end
                if (shift_enable) shifts++;
                if (acc_en) begin
                    if (pp_q.size() == 0) check_eq("pp_unexpected", 1, 0);
                    else check_eq("pp_sel", pp_sel, pp_q.pop_front());
                end
                if (out_valid && !ov_prev) begin
                    check_eq("latency", cyc - acc_cyc, Lat);
                    check_eq("shift_count", shifts, Digits);
                    if (prod_q.size() == 0) check_eq("product_unexpected", 1, 0);
                    else check_eq("product", acc, prod_q.pop_front());
                end
            end
            ov_prev = out_valid;
        end
    end

    task automatic run_op(input logic [Size-1:0] m, input logic [Size-1:0] c, input int hold);
        bit seen;
        @(posedge clk); #1;
        mult_v   = m;
        mcand_v  = c;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        if (!seen) begin
            check_eq("done_timeout", 0, 1);
            return;
        end
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            in_valid = (h % 2 == 0);
            @(negedge clk);
            check_eq("hold_out_valid", out_valid, 1);
            check_eq("hold_in_ready", in_ready, 0);
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        check_eq("idle_in_ready", in_ready, 1);
        check_eq("idle_out_valid", out_valid, 0);
        check_eq("idle_no_load", load_enable, 0);
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        abort     = 1'b0;
        mult_v    = '0;
        mcand_v   = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_clear_n", clear_n, 0);
        check_eq("rst_in_ready", in_ready, 0);
        check_eq("rst_strobes", {load_enable, shift_enable, acc_en, out_valid}, 0);
        check_eq("rst_pp_sel", pp_sel, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check_eq("post_rst_in_ready", in_ready, 1);
        check_eq("post_rst_clear_n", clear_n, 1);
        check_eq("post_rst_strobes", {load_enable, shift_enable, acc_en, out_valid}, 0);

        run_op(8'h00, 8'h07, 0);
        run_op(8'h03, 8'h05, 0);
        run_op(8'hFF, 8'h09, 0);
        run_op(8'h80, 8'hFD, 0);
        run_op(8'h5A, 8'h7F, 5);
        for (int i = 0; i < 4; i++) run_op(Size'($urandom), Size'($urandom), 0);

        // Reset in the second CALC cycle (cycle 4 after acceptance)
        @(posedge clk); #1;
        mult_v   = 8'h6B;
        mcand_v  = 8'h13;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        check_eq("midrst_clear_n", clear_n, 0);
        check_eq("midrst_acc_en", acc_en, 0);
        check_eq("midrst_in_ready", in_ready, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check_eq("midrst_idle", in_ready, 1);
        run_op(8'h6B, 8'h13, 0);

`ifdef RADIX4_MULT_CTRL_ABORT_EN
        // Abort in the first SHIFT cycle (cycle 3 after acceptance)
        @(posedge clk); #1;
        mult_v   = 8'h2D;
        mcand_v  = 8'h41;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        abort = 1'b1;
        @(negedge clk);
        check_eq("abort_shift_en", shift_enable, 0);
        check_eq("abort_clear_n", clear_n, 0);
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        check_eq("abort_idle", in_ready, 1);
        run_op(8'h2D, 8'h41, 0);
`endif

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/radix4_mult_ctrl.md
RADIX4_MULT_CTRL -- requirements
Module: radix4_mult_ctrl

Interface
REQ-001 SHALL have parameter size, default 8, multiplier operand width in bits; legal values are even and >= 4.
REQ-002 SHALL have port clk, input, 1 bit, single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit; reset is synchronous and active-high.
REQ-004 SHALL have port in_valid, input, 1 bit, operand-ready request from upstream.
REQ-005 SHALL have port in_ready, output, 1 bit, controller idle and accepting.
REQ-006 SHALL have port q_bits, input, 2 bits, serial_out of the multiplier shift register (two LSBs).
REQ-007 SHALL have port load_enable, output, 1 bit, parallel load strobe to the shift registers.
REQ-008 SHALL have port shift_enable, output, 1 bit, 2-place shift strobe to the shift registers.
REQ-009 SHALL have port clear_n, output, 1 bit, active-low synchronous clear to the shift registers.
REQ-010 SHALL have port acc_en, output, 1 bit, accumulator/adder write strobe.
REQ-011 SHALL have port pp_sel, output, 3 bits, Booth partial-product select: 000 zero, 001 +M, 010 +2M, 101 -M, 110 -2M.
REQ-012 SHALL have port out_valid, output, 1 bit, product complete in external registers.
REQ-013 SHALL have port out_ready, input, 1 bit, downstream consumed product.

Function
REQ-014 SHALL implement states IDLE, LOAD, CALC, SHIFT, DONE; all outputs are Moore outputs decoded from state, except pp_sel, which is decoded from state, q_bits and q_m1.
REQ-015 IDLE: in_ready=1, all other strobes 0, clear_n=1; in_valid=1 -> LOAD.
REQ-016 LOAD (1 cycle): load_enable=1; iteration counter cleared to 0; q_m1 cleared to 0; -> CALC.
REQ-017 CALC (1 cycle): acc_en=1; pp_sel = Booth digit of {q_bits[1],q_bits[0],q_m1}: 000/111->000, 001/010->001, 011->010, 100->110, 101/110->101; -> SHIFT.
REQ-018 SHIFT (1 cycle): shift_enable=1; q_m1 <= q_bits[1]; counter <= counter+1; -> DONE if the incremented count equals size/2, else -> CALC.
REQ-019 pp_sel SHALL be 000 in every state other than CALC.
REQ-020 Counter width SHALL be $clog2(size/2+1) bits; the counter never wraps.
REQ-021 DONE: out_valid=1 held until out_ready=1; out_valid & out_ready -> IDLE; no strobes active.
REQ-022 Latency: in_valid accepted in cycle 0 -> out_valid first high in cycle 2+size (cycle 10 for size=8).
REQ-023 in_valid outside IDLE SHALL be ignored (in_ready=0); no request is queued.
REQ-024 out_ready outside DONE SHALL be ignored.
REQ-025 load_enable, shift_enable and acc_en SHALL be mutually exclusive in every cycle.

Reset
REQ-026 reset=1 at a clock edge SHALL force IDLE, counter=0 and q_m1=0, regardless of state, including mid-operation.
REQ-027 While reset is high, clear_n SHALL be 0 so the shift registers are cleared on the same edge; all other outputs SHALL be 0, including in_ready.
REQ-028 In the first cycle after reset deasserts: in_ready=1, clear_n=1, all other outputs 0.

Configuration
REQ-029 Macro RADIX4_MULT_CTRL_ABORT_EN defined: the module SHALL add input port abort, 1 bit; abort=1 in LOAD, CALC, SHIFT or DONE SHALL drive clear_n=0 and all strobes to 0 that cycle and SHALL return to IDLE on the next edge; abort in IDLE SHALL have no effect; reset SHALL take priority over abort.
REQ-030 Macro undefined: the abort port SHALL be absent and the behaviour SHALL be exactly as specified in REQ-014 to REQ-028.

Verification
REQ-031 size=8, multiplier 0x00, in_valid pulse -> four CALC cycles with pp_sel=000; out_valid high in cycle 10.
REQ-032 size=8, multiplier 0x03 -> pp_sel sequence over the CALC cycles: 101, 001, 000, 000.
REQ-033 size=8, multiplier 0xFF -> pp_sel sequence: 101, 000, 000, 000; exactly 4 shift_enable pulses.
REQ-034 out_ready held 0 for 5 cycles in DONE -> out_valid stays 1 and in_ready stays 0; in_valid pulses in that window are dropped; out_ready=1 -> IDLE next cycle.
REQ-035 reset asserted in the second CALC cycle -> clear_n=0 that cycle; IDLE with in_ready=1 one cycle after reset deasserts; the next operation completes with correct latency.
REQ-036 With RADIX4_MULT_CTRL_ABORT_EN defined, abort=1 in a SHIFT cycle -> shift_enable=0 and clear_n=0 that cycle; in_ready=1 on the next cycle.
